// File: rtl/constants.sv
// Default reset and trap vectors for the PC controller.
package constants_pkg;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT  = 32'h0000_0100;

endpackage

// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: PC controller state and branch funct3 codes.
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_TRAP = 2'd2
  } pc_state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // A redirect target must be word aligned since there is no C extension.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Maps funct3 plus comparator flags onto the conditional-branch taken condition.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_less_i,
  input  logic       br_equal_i,
  output logic       cond_o
);

  // Codes 010/011 are not branches; they evaluate false so they never redirect.
  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      F3_BEQ:           cond_o = br_equal_i;
      F3_BNE:           cond_o = !br_equal_i;
      F3_BLT, F3_BLTU:  cond_o = br_less_i;
      F3_BGE, F3_BGEU:  cond_o = !br_less_i;
      default:          cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: branch/JAL/JALR redirect, boot bubble, misaligned trap.
// Optional perf counters enabled by defining PC_PERF_EN.
module pc_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = constants_pkg::RESET_VEC_DEFAULT,
  parameter logic [31:0] TRAP_VEC  = constants_pkg::TRAP_VEC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        is_branch_i,
  input  logic        is_jal_i,
  input  logic        is_jalr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  input  logic        br_less_i,
  input  logic        br_equal_i,
  output logic        br_unsigned_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_four_o,
  output logic        pc_valid_o,
  output logic        br_taken_o,
  output logic        trap_o,
  output logic [31:0] trap_tval_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] taken_cnt_o
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q, tval_d;

  logic        active;
  logic        condTrue;
  logic        redirect;
  logic        misaligned;
  logic [31:0] pcFour;
  logic [31:0] pcPlusImm;
  logic [31:0] jalrSum;
  logic [31:0] target;

  branch_cond u_branch_cond (
    .funct3_i   (funct3_i),
    .br_less_i  (br_less_i),
    .br_equal_i (br_equal_i),
    .cond_o     (condTrue)
  );

  assign active    = (state_q == PC_RUN) && !stall_i;
  assign pcFour    = pc_q + 32'd4;
  assign pcPlusImm = pc_q + imm_i;
  assign jalrSum   = rs1_data_i + imm_i;

  // JAL wins over JALR, which wins over a conditional branch.
  always_comb begin
    redirect = 1'b0;
    target   = pcPlusImm;
    if (is_jal_i) begin
      redirect = 1'b1;
    end else if (is_jalr_i) begin
      redirect = 1'b1;
      target   = {jalrSum[31:1], 1'b0};
    end else if (is_branch_i) begin
      redirect = condTrue;
    end
  end

  assign br_taken_o = active && redirect;
  assign misaligned = br_taken_o && !is_word_aligned(target);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tval_d  = tval_q;
    case (state_q)
      PC_BOOT: state_d = PC_RUN;
      PC_RUN: begin
        if (!stall_i) begin
          if (misaligned) begin
            state_d = PC_TRAP;
            pc_d    = TRAP_VEC;
            tval_d  = target;
          end else if (br_taken_o) begin
            pc_d = target;
          end else begin
            pc_d = pcFour;
          end
        end
      end
      PC_TRAP: state_d = PC_RUN;
      default: state_d = PC_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PC_BOOT;
      pc_q    <= RESET_VEC;
      tval_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tval_q  <= tval_d;
    end
  end

  assign br_unsigned_o = funct3_i[1];
  assign pc_o          = pc_q;
  assign pc_four_o     = pcFour;
  assign pc_valid_o    = (state_q == PC_RUN);
  assign trap_o        = (state_q == PC_TRAP);
  assign trap_tval_o   = tval_q;

`ifdef PC_PERF_EN
  logic [31:0] branchCnt_q;
  logic [31:0] takenCnt_q;

  // A misaligned taken branch still retires as a taken branch for counting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branchCnt_q <= 32'd0;
      takenCnt_q  <= 32'd0;
    end else if (active && is_branch_i) begin
      branchCnt_q <= branchCnt_q + 32'd1;
      if (condTrue) begin
        takenCnt_q <= takenCnt_q + 32'd1;
      end
    end
  end

  assign branch_cnt_o = branchCnt_q;
  assign taken_cnt_o  = takenCnt_q;
`else
  assign branch_cnt_o = 32'd0;
  assign taken_cnt_o  = 32'd0;
`endif

endmodule
